// File: rtl/counter_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_arbiter_if
// Description : Requester/response bundle for counter_arbiter.
//               master modport = requester side, slave modport = arbiter.
//   req_valid  [NUM_REQ]         per-requester command valid
//   req_ready  [NUM_REQ]         per-requester accept (one-hot or zero)
//   req_op     [2*NUM_REQ]       packed op: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD
//   req_data   [DATA_W*NUM_REQ]  packed load value
//   req_steps  [STEP_W*NUM_REQ]  packed step count
//   resp_valid / resp_id / resp_value / resp_sat   completion report
// Revision    : 1.0  initial release
// ============================================================================
interface counter_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4,
  parameter int STEP_W  = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [STEP_W*NUM_REQ-1:0] req_steps;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_value;
  logic                      resp_sat;

  modport master (
    output req_valid, req_op, req_data, req_steps,
    input  req_ready, resp_valid, resp_id, resp_value, resp_sat
  );

  modport slave (
    input  req_valid, req_op, req_data, req_steps,
    output req_ready, resp_valid, resp_id, resp_value, resp_sat
  );
endinterface
`default_nettype wire

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_arbiter
// Description : Round-robin controller sharing one free-running up/down
//               counter between NUM_REQ requesters. Commands LOAD, UP n,
//               DOWN n, HOLD; the final count is reported on the resp bus.
//               The counter is stalled by reloading its own output.
// Ports       : clk, rst        clock, synchronous active-high reset
//               bus (slave)     requester handshake + response
//               cnt_load        to counter load
//               cnt_updown      to counter updown (1 = up)
//               cnt_data        to counter data
//               cnt_value       from counter data_out
// Option      : COUNTER_ARB_SAT_EN - saturate at all-ones (UP) / zero (DOWN)
//               instead of wrapping, flagged on resp_sat.
// Revision    : 1.0  initial release
// ============================================================================
module counter_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  counter_arbiter_if.slave  bus,
  output logic              cnt_load,
  output logic              cnt_updown,
  output logic [DATA_W-1:0] cnt_data,
  input  logic [DATA_W-1:0] cnt_value
);
  localparam int            ID_W      = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [1:0]    OP_LOAD   = 2'b00;
  localparam logic [1:0]    OP_UP     = 2'b01;
  localparam logic [1:0]    OP_DOWN   = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   ptr;          // first index searched on the next grant
  logic [ID_W-1:0]   cap_id;
  logic [1:0]        cap_op;
  logic [DATA_W-1:0] cap_data;
  logic [STEP_W-1:0] rem;          // steps still to apply
  logic [ID_W-1:0]   resp_id_q;
  logic [DATA_W-1:0] resp_value_q;

  // Unpack the per-requester fields so they can be indexed by the grant.
  logic [1:0]        op_arr    [NUM_REQ];
  logic [DATA_W-1:0] data_arr  [NUM_REQ];
  logic [STEP_W-1:0] steps_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i]    = bus.req_op[2*i +: 2];
    assign data_arr[i]  = bus.req_data[DATA_W*i +: DATA_W];
    assign steps_arr[i] = bus.req_steps[STEP_W*i +: STEP_W];
  end

  // Round-robin: rotate valids so ptr lands at bit 0, take the lowest set bit,
  // then map the offset back to an absolute index.
  logic [2*NUM_REQ-1:0] valid_x2, valid_sh;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 found;
  logic [ID_W-1:0]      offset, gnt, ptr_next;
  logic [ID_W:0]        gnt_sum, ptr_sum;

  assign valid_x2  = {bus.req_valid, bus.req_valid};
  assign valid_sh  = valid_x2 >> ptr;
  assign valid_rot = valid_sh[NUM_REQ-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        found  = 1'b1;
        offset = ID_W'(k);
      end
    end
  end

  always_comb begin
    gnt_sum = {1'b0, ptr} + {1'b0, offset};
    if (gnt_sum >= NUM_REQ_W) gnt_sum = gnt_sum - NUM_REQ_W;
    gnt     = gnt_sum[ID_W-1:0];
    ptr_sum = {1'b0, gnt} + (ID_W+1)'(1);
    if (ptr_sum >= NUM_REQ_W) ptr_sum = '0;
    ptr_next = ptr_sum[ID_W-1:0];
  end

  // Saturation test on the value about to be stepped.
  logic sat_cond;
`ifdef COUNTER_ARB_SAT_EN
  logic sat_q, resp_sat_q;
  assign sat_cond = ((cap_op == OP_UP)   && (cnt_value == '1)) ||
                    ((cap_op == OP_DOWN) && (cnt_value == '0));
`else
  assign sat_cond = 1'b0;
`endif

  logic accept, step;

  always_comb begin
    next_state = state;
    cnt_load   = 1'b1;          // default: hold by reloading the current value
    cnt_updown = 1'b0;
    cnt_data   = cnt_value;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        next_state = DONE;
        if (cap_op == OP_LOAD) begin
          cnt_data = cap_data;
        end else if ((cap_op == OP_UP || cap_op == OP_DOWN) && rem != '0
                     && !sat_cond) begin
          step       = 1'b1;
          cnt_load   = 1'b0;
          cnt_updown = (cap_op == OP_UP);
          if (rem != STEP_W'(1)) next_state = RUN;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) begin
      accept     = 1'b0;
      step       = 1'b0;
      cnt_load   = 1'b0;
      cnt_updown = 1'b0;
      cnt_data   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cap_id       <= '0;
      cap_op       <= '0;
      cap_data     <= '0;
      rem          <= '0;
      resp_id_q    <= '0;
      resp_value_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        ptr      <= ptr_next;
        cap_id   <= gnt;
        cap_op   <= op_arr[gnt];
        cap_data <= data_arr[gnt];
        rem      <= steps_arr[gnt];
      end else if (step) begin
        rem <= rem - STEP_W'(1);
      end
      if (state == DONE) begin
        resp_id_q    <= cap_id;
        resp_value_q <= cnt_value;
      end
    end
  end

`ifdef COUNTER_ARB_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q      <= 1'b0;
      resp_sat_q <= 1'b0;
    end else begin
      if (accept) sat_q <= 1'b0;
      else if (state == RUN && sat_cond) sat_q <= 1'b1;
      if (state == DONE) resp_sat_q <= sat_q;
    end
  end
`endif

  // resp_value is taken live in DONE so it includes the final step; the
  // registered copies keep the bus stable between completions.
  logic in_done;
  assign in_done        = (state == DONE) && !rst;
  assign bus.req_ready  = (accept) ? (NUM_REQ'(1) << gnt) : '0;
  assign bus.resp_valid = in_done;
  assign bus.resp_id    = in_done ? cap_id    : resp_id_q;
  assign bus.resp_value = in_done ? cnt_value : resp_value_q;
`ifdef COUNTER_ARB_SAT_EN
  assign bus.resp_sat   = in_done ? sat_q : resp_sat_q;
`else
  assign bus.resp_sat   = 1'b0;
`endif

endmodule
`default_nettype wire
